// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, op codes, legality check and
// the arbiter priority-pointer encoding.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_e;

    function automatic logic alu_op_legal(input logic [3:0] op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Unknown control codes produce a zero result,
// so the zero flag is set for them.
module alu
    import alu_pkg::*;
(
    input  logic [3:0]        ctrl,
    input  logic [DATA_W-1:0] input1,
    input  logic [DATA_W-1:0] input2,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_AND: result = input1 & input2;
            ALU_OR:  result = input1 | input2;
            ALU_ADD: result = input1 + input2;
            ALU_SUB: result = input1 - input2;
            // Unsigned compare.
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, (input1 < input2)};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, each with a
// one-entry response buffer returned over its own valid/ready channel.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp0_illegal,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic              rsp1_illegal,
    output logic              busy,
    output logic              dbg_ptr
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the sender holds its payload stable while valid && !ready.

    pri_e              r_ptr;
    logic              r_rsp0_valid;
    logic [DATA_W-1:0] r_rsp0_result;
    logic              r_rsp0_zero;
    logic              r_rsp0_illegal;
    logic              r_rsp1_valid;
    logic [DATA_W-1:0] r_rsp1_result;
    logic              r_rsp1_zero;
    logic              r_rsp1_illegal;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_grant0;
    logic              w_grant1;
    logic [3:0]        w_op;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_result;
    logic              w_zero;
    logic              w_illegal;

    // A full buffer being drained this cycle can be refilled in the same cycle.
    assign w_elig0 = req0_valid && (!r_rsp0_valid || rsp0_ready);
    assign w_elig1 = req1_valid && (!r_rsp1_valid || rsp1_ready);

    assign w_grant0 = rst_n && w_elig0 && (!w_elig1 || (r_ptr == PRI0));
    assign w_grant1 = rst_n && w_elig1 && (!w_elig0 || (r_ptr == PRI1));

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    assign w_op = w_grant1 ? req1_op : req0_op;
    assign w_a  = w_grant1 ? req1_a  : req0_a;
    assign w_b  = w_grant1 ? req1_b  : req0_b;

    alu u_alu (
        .ctrl   (w_op),
        .input1 (w_a),
        .input2 (w_b),
        .result (w_result),
        .zero   (w_zero)
    );

    assign w_illegal = !alu_op_legal(w_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr          <= PRI0;
            r_rsp0_valid   <= 1'b0;
            r_rsp0_result  <= '0;
            r_rsp0_zero    <= 1'b0;
            r_rsp0_illegal <= 1'b0;
            r_rsp1_valid   <= 1'b0;
            r_rsp1_result  <= '0;
            r_rsp1_zero    <= 1'b0;
            r_rsp1_illegal <= 1'b0;
        end else begin
            if (w_grant0) begin
                r_ptr <= PRI1;
            end else if (w_grant1) begin
                r_ptr <= PRI0;
            end

            if (w_grant0) begin
                r_rsp0_valid   <= 1'b1;
                r_rsp0_result  <= w_result;
                r_rsp0_zero    <= w_zero;
                r_rsp0_illegal <= w_illegal;
            end else if (rsp0_ready) begin
                r_rsp0_valid   <= 1'b0;
            end

            if (w_grant1) begin
                r_rsp1_valid   <= 1'b1;
                r_rsp1_result  <= w_result;
                r_rsp1_zero    <= w_zero;
                r_rsp1_illegal <= w_illegal;
            end else if (rsp1_ready) begin
                r_rsp1_valid   <= 1'b0;
            end
        end
    end

    assign rsp0_valid   = r_rsp0_valid;
    assign rsp0_result  = r_rsp0_result;
    assign rsp0_zero    = r_rsp0_zero;
    assign rsp0_illegal = r_rsp0_illegal;
    assign rsp1_valid   = r_rsp1_valid;
    assign rsp1_result  = r_rsp1_result;
    assign rsp1_zero    = r_rsp1_zero;
    assign rsp1_illegal = r_rsp1_illegal;
    assign busy         = r_rsp0_valid || r_rsp1_valid;
    assign dbg_ptr      = (r_ptr == PRI1);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single op, contention, backpressure,
// arithmetic edges, illegal op and reset while a response is buffered.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_illegal;
    logic [31:0] rsp0_result;
    logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_illegal;
    logic [31:0] rsp1_result;
    logic        busy;
    logic        dbg_ptr;

    int errors = 0;
    int checks = 0;

    alu_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_op      (req0_op),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_op      (req1_op),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .rsp0_valid   (rsp0_valid),
        .rsp0_ready   (rsp0_ready),
        .rsp0_result  (rsp0_result),
        .rsp0_zero    (rsp0_zero),
        .rsp0_illegal (rsp0_illegal),
        .rsp1_valid   (rsp1_valid),
        .rsp1_ready   (rsp1_ready),
        .rsp1_result  (rsp1_result),
        .rsp1_zero    (rsp1_zero),
        .rsp1_illegal (rsp1_illegal),
        .busy         (busy),
        .dbg_ptr      (dbg_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd1; req1_b = 32'd1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
        end
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got v0=%b v1=%b busy=%b expected 0", rsp0_valid, rsp1_valid, busy);
        end
        checks++;
        if (rsp0_result !== 32'd0 || rsp1_result !== 32'd0 || rsp0_zero !== 1'b0 ||
            rsp1_zero !== 1'b0 || rsp0_illegal !== 1'b0 || rsp1_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: got r0=%h r1=%h z=%b%b i=%b%b expected all 0",
                     rsp0_result, rsp1_result, rsp0_zero, rsp1_zero, rsp0_illegal, rsp1_illegal);
        end
        checks++;
        if (dbg_ptr !== 1'b0) begin
            errors++;
            $display("FAIL reset_ptr: got %b expected 0", dbg_ptr);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_op();
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd5; req0_b = 32'd7;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b expected 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd12 || rsp0_zero !== 1'b0 ||
            rsp0_illegal !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_rsp: got v=%b r=%h z=%b i=%b busy=%b expected 1 0000000c 0 0 1",
                     rsp0_valid, rsp0_result, rsp0_zero, rsp0_illegal, busy);
        end
        checks++;
        if (dbg_ptr !== 1'b1) begin
            errors++;
            $display("FAIL single_ptr: got %b expected 1", dbg_ptr);
        end
        rsp0_ready = 1'b1;
        tick();
        checks++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0 || rsp0_result !== 32'd12) begin
            errors++;
            $display("FAIL single_drain: got v=%b busy=%b r=%h expected 0 0 0000000c",
                     rsp0_valid, busy, rsp0_result);
        end
        rsp0_ready = 1'b0;
    endtask

    task automatic test_contention();
        logic exp0;
        apply_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 4'b0110; req0_a = 32'd9;    req0_b = 32'd9;
        req1_valid = 1'b1; req1_op = 4'b0001; req1_a = 32'hF0;   req1_b = 32'h0F;
        for (int i = 0; i < 4; i++) begin
            exp0 = (i % 2 == 0);
            #1;
            checks++;
            if (req0_ready !== exp0 || req1_ready !== !exp0) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got %b%b expected %b%b",
                         i, req0_ready, req1_ready, exp0, !exp0);
            end
            tick();
            if (exp0) begin
                checks++;
                if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd0 || rsp0_zero !== 1'b1 ||
                    rsp1_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL contention_rsp0[%0d]: got v0=%b r=%h z=%b v1=%b expected 1 0 1 0",
                             i, rsp0_valid, rsp0_result, rsp0_zero, rsp1_valid);
                end
            end else begin
                checks++;
                if (rsp1_valid !== 1'b1 || rsp1_result !== 32'hFF || rsp1_zero !== 1'b0 ||
                    rsp0_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL contention_rsp1[%0d]: got v1=%b r=%h z=%b v0=%b expected 1 ff 0 0",
                             i, rsp1_valid, rsp1_result, rsp1_zero, rsp0_valid);
                end
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        rsp0_ready = 1'b1; rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd1; req1_b = 32'd2;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first_ready: got %b expected 1", req1_ready);
        end
        tick();
        req1_op = 4'b0000; req1_a = 32'hC; req1_b = 32'hA;
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd10; req0_b = 32'd20;
        #1;
        checks++;
        if (req1_ready !== 1'b0 || req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd30 || rsp1_valid !== 1'b1 ||
            rsp1_result !== 32'd3) begin
            errors++;
            $display("FAIL bp_other: got v0=%b r0=%h v1=%b r1=%h expected 1 1e 1 3",
                     rsp0_valid, rsp0_result, rsp1_valid, rsp1_result);
        end
        #1;
        checks++;
        if (req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: got %b expected 0", req1_ready);
        end
        tick();
        rsp1_ready = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_pulse_ready: got %b expected 1", req1_ready);
        end
        tick();
        rsp1_ready = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd8 || rsp1_zero !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_rsp: got v=%b r=%h z=%b expected 1 8 0",
                     rsp1_valid, rsp1_result, rsp1_zero);
        end
        tick();
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd8) begin
            errors++;
            $display("FAIL bp_held_rsp: got v=%b r=%h expected 1 8", rsp1_valid, rsp1_result);
        end
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
    endtask

    task automatic test_arith_edges();
        logic [3:0]  ops  [6] = '{4'b0010, 4'b0110, 4'b0111, 4'b0111, 4'b0000, 4'b0001};
        logic [31:0] as   [6] = '{32'hFFFFFFFF, 32'd0, 32'h80000000, 32'd1, 32'hF0F0, 32'hF000};
        logic [31:0] bs   [6] = '{32'd1, 32'd1, 32'd1, 32'd2, 32'h0F0F, 32'h000F};
        logic [31:0] exps [6] = '{32'd0, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd0, 32'hF00F};
        logic        expz [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        rsp0_ready = 1'b1;
        req0_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_op = ops[i]; req0_a = as[i]; req0_b = bs[i];
            #1;
            checks++;
            if (req0_ready !== 1'b1) begin
                errors++;
                $display("FAIL arith_ready[%0d]: got %b expected 1", i, req0_ready);
            end
            tick();
            checks++;
            if (rsp0_valid !== 1'b1 || rsp0_result !== exps[i] || rsp0_zero !== expz[i] ||
                rsp0_illegal !== 1'b0) begin
                errors++;
                $display("FAIL arith_rsp[%0d]: got v=%b r=%h z=%b i=%b expected 1 %h %b 0",
                         i, rsp0_valid, rsp0_result, rsp0_zero, rsp0_illegal, exps[i], expz[i]);
            end
        end
        req0_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        rsp1_ready = 1'b1;
        req1_valid = 1'b1; req1_op = 4'b0011; req1_a = 32'd5; req1_b = 32'd3;
        tick();
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd0 || rsp1_zero !== 1'b1 ||
            rsp1_illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_rsp: got v=%b r=%h z=%b i=%b expected 1 0 1 1",
                     rsp1_valid, rsp1_result, rsp1_zero, rsp1_illegal);
        end
        req1_op = 4'b0010;
        tick();
        req1_valid = 1'b0;
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd8 || rsp1_zero !== 1'b0 ||
            rsp1_illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: got v=%b r=%h z=%b i=%b expected 1 8 0 0",
                     rsp1_valid, rsp1_result, rsp1_zero, rsp1_illegal);
        end
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    task automatic test_reset_mid_flight();
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd3; req0_b = 32'd4;
        tick();
        req0_valid = 1'b0;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 32'd7) begin
            errors++;
            $display("FAIL mid_pre: got v=%b r=%h expected 1 7", rsp0_valid, rsp0_result);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0 || rsp0_result !== 32'd0) begin
            errors++;
            $display("FAIL mid_async: got v=%b busy=%b r=%h expected 0 0 0",
                     rsp0_valid, busy, rsp0_result);
        end
        tick();
        rst_n = 1'b1;
        checks++;
        if (dbg_ptr !== 1'b0) begin
            errors++;
            $display("FAIL mid_ptr: got %b expected 0", dbg_ptr);
        end
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_first_grant: got %b%b expected 10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_arith_edges();
        test_illegal();
        test_reset_mid_flight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
